nmea_rmc_ctrl: RTL and testbench

NMEA_RMC_CTRL -- requirements
Module: nmea_rmc_ctrl

---
 rtl/nmea_pkg.sv | 37 +++
 rtl/bcd_hour_offset.sv | 41 ++++
 rtl/nmea_rmc_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_nmea_rmc_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// nmea_pkg: FSM states, ASCII constants and hex helpers for the RMC time decoder.
// Latency: n/a (declarations only). Backpressure: n/a.
// NMEA_CHECKSUM_EN adds the checksum states CK_HI/CK_LO to the state enum.
package nmea_pkg;

`ifdef NMEA_CHECKSUM_EN
    typedef enum logic [2:0] { IDLE, ADDR, FIELDS, CK_HI, CK_LO } state_t;
`else
    typedef enum logic [1:0] { IDLE, ADDR, FIELDS } state_t;
`endif

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_A      = 8'h41;
    localparam logic [7:0] CH_G      = 8'h47;
    localparam logic [7:0] CH_P      = 8'h50;
    localparam logic [7:0] CH_N      = 8'h4E;
    localparam logic [7:0] CH_R      = 8'h52;
    localparam logic [7:0] CH_M      = 8'h4D;
    localparam logic [7:0] CH_C      = 8'h43;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Uppercase hex only; lowercase letters are treated as garbage.
    function automatic logic is_hex(input logic [7:0] c);
        return is_digit(c) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // '0'..'9' map through their low nibble; 'A'..'F' have low nibble 1..6, so add 9.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        return is_digit(c) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

endpackage

// File: rtl/bcd_hour_offset.sv
// bcd_hour_offset: adds a fixed UTC offset to a two-digit BCD hour, wrapping mod 24.
// Latency: combinational. Backpressure: none.
// The input digits are not range-checked; any value up to 9:9 still yields a valid 0..23 hour.
module bcd_hour_offset #(
    parameter int UTC_OFFSET = 8
) (
    input  logic [7:0] hour_i,
    output logic [7:0] hour_o
);

    localparam logic [7:0] OFS = 8'(UTC_OFFSET % 24);

    logic [7:0] sum;
    logic [7:0] bin;
    logic [3:0] tens;
    logic [3:0] ones;

    // Binary hour plus offset, reduce mod 24, then split back into BCD digits.
    always_comb begin
        sum = ({4'd0, hour_i[7:4]} * 8'd10) + {4'd0, hour_i[3:0]} + OFS;
        bin = sum;
        // Worst case 15*10+15+23 = 188 needs at most 7 subtractions.
        for (int i = 0; i < 8; i++) begin
            if (bin >= 8'd24) begin
                bin = bin - 8'd24;
            end
        end
        if (bin >= 8'd20) begin
            tens = 4'd2;
            ones = 4'(bin - 8'd20);
        end else if (bin >= 8'd10) begin
            tens = 4'd1;
            ones = 4'(bin - 8'd10);
        end else begin
            tens = 4'd0;
            ones = bin[3:0];
        end
        hour_o = {tens, ones};
    end

endmodule

// File: rtl/nmea_rmc_ctrl.sv
// nmea_rmc_ctrl: parses $G[PN]RMC sentences from a UART byte stream into local BCD time and fix flag.
// Latency: outputs register one cycle after the committing byte strobe. Backpressure: none, every rx_flag byte is consumed.
// NMEA_CHECKSUM_EN: verify the two hex digits after '*' and commit on the last one; otherwise commit on '*'.
module nmea_rmc_ctrl
    import nmea_pkg::*;
#(
    parameter int UTC_OFFSET  = 8,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    output logic [23:0] time_bcd,
    output logic        fix_valid,
    output logic        time_flag,
    output logic        frame_err
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [2:0]         addr_idx_q, addr_idx_d;
    logic [1:0]         field_q, field_d;      // saturates at 3: only fields 1 and 2 matter
    logic [2:0]         char_idx_q, char_idx_d; // saturates at 7
    logic [23:0]        digits_q, digits_d;    // raw UTC {hh,mm,ss}
    logic               time_ok_q, time_ok_d;
    logic               fix_q, fix_d;
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [23:0]        time_bcd_q, time_bcd_d;
    logic               fix_valid_q, fix_valid_d;
    logic               time_flag_q, time_flag_d;
    logic               frame_err_q, frame_err_d;
`ifdef NMEA_CHECKSUM_EN
    logic [7:0]         acc_q, acc_d;
    logic [3:0]         ck_hi_q, ck_hi_d;
`endif

    logic               is_dollar, is_star, is_comma, addr_ok, in_time_field, timeout_hit;
    logic [7:0]         local_hour;

    assign is_dollar     = (rx_data == CH_DOLLAR);
    assign is_star       = (rx_data == CH_STAR);
    assign is_comma      = (rx_data == CH_COMMA);
    assign in_time_field = (field_q == 2'd1) && (char_idx_q < 3'd6);
    assign timeout_hit   = (state_q != IDLE) && !rx_flag && (to_cnt_q == TO_LAST);

    // Expected address character for the current position in "G[PN]RMC,".
    always_comb begin
        case (addr_idx_q)
            3'd0:    addr_ok = (rx_data == CH_G);
            3'd1:    addr_ok = (rx_data == CH_P) || (rx_data == CH_N);
            3'd2:    addr_ok = (rx_data == CH_R);
            3'd3:    addr_ok = (rx_data == CH_M);
            3'd4:    addr_ok = (rx_data == CH_C);
            3'd5:    addr_ok = is_comma;
            default: addr_ok = 1'b0;
        endcase
    end

    bcd_hour_offset #(.UTC_OFFSET(UTC_OFFSET)) u_hour (
        .hour_i (digits_q[23:16]),
        .hour_o (local_hour)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; '$' restarts the sentence from any state.
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (rx_flag) begin
            if (is_dollar) begin
                state_d = ADDR;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (!addr_ok) begin
                            state_d = IDLE;
                        end else if (addr_idx_q == 3'd5) begin
                            state_d = FIELDS;
                        end
                    end
                    FIELDS: begin
                        if (is_star) begin
`ifdef NMEA_CHECKSUM_EN
                            state_d = time_ok_q ? CK_HI : IDLE;
`else
                            state_d = IDLE;
`endif
                        end else if (in_time_field) begin
                            if (is_comma) begin
                                if (char_idx_q == 3'd0) begin
                                    state_d = IDLE;
                                end
                            end else if (!is_digit(rx_data)) begin
                                state_d = IDLE;
                            end
                        end
                    end
`ifdef NMEA_CHECKSUM_EN
                    CK_HI:   state_d = is_hex(rx_data) ? CK_LO : IDLE;
                    CK_LO:   state_d = IDLE;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Datapath and output strobes; commit and abort are mutually exclusive branches.
    always_comb begin
        addr_idx_d  = addr_idx_q;
        field_d     = field_q;
        char_idx_d  = char_idx_q;
        digits_d    = digits_q;
        time_ok_d   = time_ok_q;
        fix_d       = fix_q;
        time_bcd_d  = time_bcd_q;
        fix_valid_d = fix_valid_q;
        time_flag_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef NMEA_CHECKSUM_EN
        acc_d       = acc_q;
        ck_hi_d     = ck_hi_q;
`endif
        if (rx_flag || (state_q == IDLE) || timeout_hit) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end

        if (timeout_hit) begin
            frame_err_d = 1'b1;
        end else if (rx_flag) begin
            if (is_dollar) begin
                addr_idx_d = 3'd0;
                field_d    = 2'd0;
                char_idx_d = 3'd0;
                time_ok_d  = 1'b0;
                fix_d      = 1'b0;
`ifdef NMEA_CHECKSUM_EN
                acc_d      = 8'h00;
`endif
            end else begin
                case (state_q)
                    ADDR: begin
`ifdef NMEA_CHECKSUM_EN
                        acc_d = acc_q ^ rx_data;
`endif
                        addr_idx_d = addr_idx_q + 3'd1;
                        field_d    = 2'd1;
                        char_idx_d = 3'd0;
                    end
                    FIELDS: begin
                        if (is_star) begin
`ifndef NMEA_CHECKSUM_EN
                            if (time_ok_q) begin
                                time_flag_d = 1'b1;
                                time_bcd_d  = {local_hour, digits_q[15:0]};
                                fix_valid_d = fix_q;
                            end
`endif
                        end else begin
`ifdef NMEA_CHECKSUM_EN
                            acc_d = acc_q ^ rx_data;
`endif
                            if (is_comma) begin
                                if (field_q != 2'd3) begin
                                    field_d = field_q + 2'd1;
                                end
                                char_idx_d = 3'd0;
                            end else begin
                                if (in_time_field) begin
                                    if (is_digit(rx_data)) begin
                                        case (char_idx_q)
                                            3'd0:    digits_d[23:20] = rx_data[3:0];
                                            3'd1:    digits_d[19:16] = rx_data[3:0];
                                            3'd2:    digits_d[15:12] = rx_data[3:0];
                                            3'd3:    digits_d[11:8]  = rx_data[3:0];
                                            3'd4:    digits_d[7:4]   = rx_data[3:0];
                                            default: digits_d[3:0]   = rx_data[3:0];
                                        endcase
                                        if (char_idx_q == 3'd5) begin
                                            time_ok_d = 1'b1;
                                        end
                                    end else begin
                                        frame_err_d = 1'b1;
                                    end
                                end
                                if ((field_q == 2'd2) && (char_idx_q == 3'd0)) begin
                                    fix_d = (rx_data == CH_A);
                                end
                                if (char_idx_q != 3'd7) begin
                                    char_idx_d = char_idx_q + 3'd1;
                                end
                            end
                        end
                    end
`ifdef NMEA_CHECKSUM_EN
                    CK_HI: begin
                        if (is_hex(rx_data)) begin
                            ck_hi_d = hex_to_nibble(rx_data);
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                    CK_LO: begin
                        if (is_hex(rx_data) && ({ck_hi_q, hex_to_nibble(rx_data)} == acc_q)) begin
                            time_flag_d = 1'b1;
                            time_bcd_d  = {local_hour, digits_q[15:0]};
                            fix_valid_d = fix_q;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Parser context and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_idx_q  <= 3'd0;
            field_q     <= 2'd0;
            char_idx_q  <= 3'd0;
            digits_q    <= 24'h0;
            time_ok_q   <= 1'b0;
            fix_q       <= 1'b0;
            to_cnt_q    <= '0;
            time_bcd_q  <= 24'h0;
            fix_valid_q <= 1'b0;
            time_flag_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
            acc_q       <= 8'h00;
            ck_hi_q     <= 4'h0;
`endif
        end else begin
            addr_idx_q  <= addr_idx_d;
            field_q     <= field_d;
            char_idx_q  <= char_idx_d;
            digits_q    <= digits_d;
            time_ok_q   <= time_ok_d;
            fix_q       <= fix_d;
            to_cnt_q    <= to_cnt_d;
            time_bcd_q  <= time_bcd_d;
            fix_valid_q <= fix_valid_d;
            time_flag_q <= time_flag_d;
            frame_err_q <= frame_err_d;
`ifdef NMEA_CHECKSUM_EN
            acc_q       <= acc_d;
            ck_hi_q     <= ck_hi_d;
`endif
        end
    end

    assign time_bcd  = time_bcd_q;
    assign fix_valid = fix_valid_q;
    assign time_flag = time_flag_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_nmea_rmc_ctrl.sv
// Directed bench for nmea_rmc_ctrl (UTC_OFFSET=8, short timeout).
// Pulses are counted on the falling edge; each step compares pulse deltas and held outputs.
// Expectations for the corrupted-checksum step follow NMEA_CHECKSUM_EN.
module tb_nmea_rmc_ctrl;

    localparam int TO = 40;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic [23:0] time_bcd;
    logic        fix_valid;
    logic        time_flag;
    logic        frame_err;

    int n_checks = 0;
    int n_err    = 0;
    int tf_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int tf0, fe0;

    nmea_rmc_ctrl #(.UTC_OFFSET(8), .TIMEOUT_CYC(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_data   (rx_data),
        .rx_flag   (rx_flag),
        .time_bcd  (time_bcd),
        .fix_valid (fix_valid),
        .time_flag (time_flag),
        .frame_err (frame_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (time_flag) tf_cnt++;
        if (frame_err) fe_cnt++;
        if (time_flag && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        rx_data = b;
        rx_flag = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_flag = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    // '$' + body + '*' + checksum (XOR of body, plus delta) + CR LF.
    task automatic send_sentence(input string body, input logic [7:0] delta);
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'h24);
        for (int i = 0; i < body.len(); i++) begin
            x = x ^ body[i];
            send_byte(body[i]);
        end
        send_byte(8'h2A);
        x = x + delta;
        send_byte(hexc(x[7:4]));
        send_byte(hexc(x[3:0]));
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic mark();
        tf0 = tf_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic settle();
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rx_data   = 8'h00;
        rx_flag   = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_time", 32'(time_bcd), 32'h0);
        chk("rst_fix",  32'(fix_valid), 32'h0);
        chk("rst_tf",   32'(time_flag), 32'h0);
        chk("rst_fe",   32'(frame_err), 32'h0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // 12:35:19 UTC +8 -> 20:35:19, fix A
        mark();
        send_sentence("GPRMC,123519.00,A,4807.038,N", 8'h00);
        settle();
        chk("s1_tf",   32'(tf_cnt - tf0), 32'd1);
        chk("s1_fe",   32'(fe_cnt - fe0), 32'd0);
        chk("s1_time", 32'(time_bcd), 32'h203519);
        chk("s1_fix",  32'(fix_valid), 32'd1);

        // 18:30:00 +8 wraps to 02:30:00, status V
        mark();
        send_sentence("GNRMC,183000.00,V,,", 8'h00);
        settle();
        chk("s2_tf",   32'(tf_cnt - tf0), 32'd1);
        chk("s2_time", 32'(time_bcd), 32'h023000);
        chk("s2_fix",  32'(fix_valid), 32'd0);

        // 23:59:59 +8 -> 07:59:59, no fractional part
        mark();
        send_sentence("GPRMC,235959,A", 8'h00);
        settle();
        chk("s3_tf",   32'(tf_cnt - tf0), 32'd1);
        chk("s3_time", 32'(time_bcd), 32'h075959);
        chk("s3_fix",  32'(fix_valid), 32'd1);

        // checksum off by one
        mark();
        send_sentence("GPRMC,101010.00,V", 8'h01);
        settle();
`ifdef NMEA_CHECKSUM_EN
        chk("badck_tf",   32'(tf_cnt - tf0), 32'd0);
        chk("badck_fe",   32'(fe_cnt - fe0), 32'd1);
        chk("badck_time", 32'(time_bcd), 32'h075959);
        chk("badck_fix",  32'(fix_valid), 32'd1);
`else
        chk("badck_tf",   32'(tf_cnt - tf0), 32'd1);
        chk("badck_fe",   32'(fe_cnt - fe0), 32'd0);
        chk("badck_time", 32'(time_bcd), 32'h181010);
        chk("badck_fix",  32'(fix_valid), 32'd0);
`endif

        // wrong sentence type and empty time field: silent
        mark();
        send_sentence("GPGGA,123519.00,1", 8'h00);
        send_sentence("GPRMC,,V,", 8'h00);
        settle();
        chk("ign_tf", 32'(tf_cnt - tf0), 32'd0);
        chk("ign_fe", 32'(fe_cnt - fe0), 32'd0);

        // non-digit inside time field
        mark();
        send_sentence("GPRMC,12a519.00,A", 8'h00);
        settle();
        chk("nd_tf", 32'(tf_cnt - tf0), 32'd0);
        chk("nd_fe", 32'(fe_cnt - fe0), 32'd1);

        // '$' mid-time-field restarts quietly, then 06:15:00 +8 -> 14:15:00
        mark();
        send_str("$GPRMC,12");
        send_sentence("GPRMC,061500.00,V", 8'h00);
        settle();
        chk("rs_tf",   32'(tf_cnt - tf0), 32'd1);
        chk("rs_fe",   32'(fe_cnt - fe0), 32'd0);
        chk("rs_time", 32'(time_bcd), 32'h141500);
        chk("rs_fix",  32'(fix_valid), 32'd0);

        // inter-byte timeout
        mark();
        send_str("$GPRMC,12");
        repeat (TO - 3) @(negedge sys_clk);
        chk("to_early_fe", 32'(fe_cnt - fe0), 32'd0);
        repeat (8) @(negedge sys_clk);
        chk("to_fe", 32'(fe_cnt - fe0), 32'd1);
        send_str("3519.00,A*00\r\n");
        settle();
        chk("to_tf", 32'(tf_cnt - tf0), 32'd0);

        // reset mid-sentence
        mark();
        send_str("$GPRMC,1235");
        #1 sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("mrst_time", 32'(time_bcd), 32'h0);
        chk("mrst_fix",  32'(fix_valid), 32'd0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        send_str("19.00,A*00\r\n");
        settle();
        chk("mrst_tf",   32'(tf_cnt - tf0), 32'd0);
        chk("mrst_time2", 32'(time_bcd), 32'h0);

        // back to normal after reset
        mark();
        send_sentence("GPRMC,123519.00,A", 8'h00);
        settle();
        chk("end_tf",   32'(tf_cnt - tf0), 32'd1);
        chk("end_time", 32'(time_bcd), 32'h203519);
        chk("excl",     32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
